synth_multi_region_dual_port_memory: RTL and testbench

- Parametrised successor to the team's split instruction/data dual-port memory.
- Two independent ports share an instruction region and a data region. Each port has a request/ack handshake, byte-lane write strobes, alignment and range checking, and same-address write-collision resolution.
- Serves the pipelined core: port 0 handles instruction fetch and debug, port 1 handles load/store and IO.

---
 rtl/synth_multi_region_dual_port_memory.sv | 191 +++++++++++++++++++
 tb/tb_synth_multi_region_dual_port_memory.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/synth_multi_region_dual_port_memory.sv
// Two-port memory with separate instruction and data regions, byte strobes and collision detect.
// Optional macro MEM_OUT_REG_EN adds one output register stage (latency 2).

module synth_multi_region_dual_port_memory_lane #(
   parameter int DEPTH = 512,
   parameter int IW    = 9
) (
   input  logic          clk,
   input  logic          we0,
   input  logic          we1,
   input  logic          re0,
   input  logic          re1,
   input  logic [IW-1:0] idx0,
   input  logic [IW-1:0] idx1,
   input  logic [7:0]    wd0,
   input  logic [7:0]    wd1,
   output logic [7:0]    rd0,
   output logic [7:0]    rd1
);
   logic [7:0] mem [DEPTH];
   logic [7:0] rd0_q, rd1_q;

   // Reads sample the old word; port 0 is written last so it wins a shared index.
   always_ff @(posedge clk) begin
      if (re0) rd0_q <= mem[idx0];
      if (re1) rd1_q <= mem[idx1];
      if (we1) mem[idx1] <= wd1;
      if (we0) mem[idx0] <= wd0;
   end

   assign rd0 = rd0_q;
   assign rd1 = rd1_q;
endmodule

module synth_multi_region_dual_port_memory #(
   parameter int          N       = 32,
   parameter int          AW      = 32,
   parameter int          I_DEPTH = 512,
   parameter int          I_IW    = 9,
   parameter int          D_DEPTH = 1024,
   parameter int          D_IW    = 10,
   parameter logic [11:0] I_TAG   = 12'h400
) (
   input  logic           clk,
   input  logic           rstb,
   input  logic           req0,
   input  logic           req1,
   input  logic           wr_ena0,
   input  logic           wr_ena1,
   input  logic [N/8-1:0] be0,
   input  logic [N/8-1:0] be1,
   input  logic [AW-1:0]  addr0,
   input  logic [AW-1:0]  addr1,
   input  logic [N-1:0]   din0,
   input  logic [N-1:0]   din1,
   output logic [N-1:0]   dout0,
   output logic [N-1:0]   dout1,
   output logic           ack0,
   output logic           ack1,
   output logic           err0,
   output logic           err1,
   output logic           collision
);
   localparam int NB = N / 8;

   logic [1:0]           req, wr, err, is_i, acc, rd_ok, wr_ok;
   logic [1:0][NB-1:0]   be;
   logic [1:0][AW-1:0]   addr;
   logic [1:0][N-1:0]    din;
   logic [1:0][I_IW-1:0] iidx;
   logic [1:0][D_IW-1:0] didx;
   logic [1:0][N-1:0]    irdata, drdata, dout_c;

   logic       arm_q;
   logic [1:0] ack_q, err_q, vld_q, reg_q;
   logic       coll_q;
   logic       same_word;

   assign req  = {req1, req0};
   assign wr   = {wr_ena1, wr_ena0};
   assign be   = {be1, be0};
   assign addr = {addr1, addr0};
   assign din  = {din1, din0};

   for (genvar p = 0; p < 2; p++) begin : g_dec
      logic mis, oor;
      assign is_i[p]  = addr[p][AW-1:AW-12] == I_TAG;
      assign iidx[p]  = addr[p][I_IW+1:2];
      assign didx[p]  = addr[p][D_IW+1:2];
      assign mis      = |addr[p][1:0];
      assign oor      = is_i[p] ? |addr[p][AW-13:I_IW+2] : |addr[p][AW-13:D_IW+2];
      assign err[p]   = mis | oor;
      assign acc[p]   = req[p] & arm_q;
      assign wr_ok[p] = acc[p] & wr[p] & ~err[p];
      assign rd_ok[p] = acc[p] & ~wr[p] & ~err[p];
      assign dout_c[p] = vld_q[p] ? (reg_q[p] ? irdata[p] : drdata[p]) : '0;
   end

   for (genvar k = 0; k < NB; k++) begin : g_lane
      synth_multi_region_dual_port_memory_lane #(.DEPTH(I_DEPTH), .IW(I_IW)) u_ilane (
         .clk (clk),
         .we0 (wr_ok[0] & is_i[0] & be[0][k]),
         .we1 (wr_ok[1] & is_i[1] & be[1][k]),
         .re0 (rd_ok[0] & is_i[0]),
         .re1 (rd_ok[1] & is_i[1]),
         .idx0(iidx[0]),
         .idx1(iidx[1]),
         .wd0 (din[0][k*8 +: 8]),
         .wd1 (din[1][k*8 +: 8]),
         .rd0 (irdata[0][k*8 +: 8]),
         .rd1 (irdata[1][k*8 +: 8])
      );
      synth_multi_region_dual_port_memory_lane #(.DEPTH(D_DEPTH), .IW(D_IW)) u_dlane (
         .clk (clk),
         .we0 (wr_ok[0] & ~is_i[0] & be[0][k]),
         .we1 (wr_ok[1] & ~is_i[1] & be[1][k]),
         .re0 (rd_ok[0] & ~is_i[0]),
         .re1 (rd_ok[1] & ~is_i[1]),
         .idx0(didx[0]),
         .idx1(didx[1]),
         .wd0 (din[0][k*8 +: 8]),
         .wd1 (din[1][k*8 +: 8]),
         .rd0 (drdata[0][k*8 +: 8]),
         .rd1 (drdata[1][k*8 +: 8])
      );
   end

   assign same_word = (is_i[0] == is_i[1]) &&
                      (is_i[0] ? (iidx[0] == iidx[1]) : (didx[0] == didx[1]));

   // arm_q blocks any request still held across reset release.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         arm_q  <= 1'b0;
         ack_q  <= '0;
         err_q  <= '0;
         vld_q  <= '0;
         reg_q  <= '0;
         coll_q <= 1'b0;
      end else begin
         arm_q  <= 1'b1;
         ack_q  <= acc;
         err_q  <= acc & err;
         coll_q <= wr_ok[0] & wr_ok[1] & same_word;
         for (int p = 0; p < 2; p++) begin
            if (rd_ok[p]) begin
               vld_q[p] <= 1'b1;
               reg_q[p] <= is_i[p];
            end else if (acc[p] & err[p]) begin
               vld_q[p] <= 1'b0;
            end
         end
      end
   end

`ifdef MEM_OUT_REG_EN
   logic [1:0][N-1:0] dout_q;
   logic [1:0]        ack2_q, err2_q;
   logic              coll2_q;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         dout_q  <= '0;
         ack2_q  <= '0;
         err2_q  <= '0;
         coll2_q <= 1'b0;
      end else begin
         dout_q  <= dout_c;
         ack2_q  <= ack_q;
         err2_q  <= err_q;
         coll2_q <= coll_q;
      end
   end

   assign dout0     = dout_q[0];
   assign dout1     = dout_q[1];
   assign ack0      = ack2_q[0];
   assign ack1      = ack2_q[1];
   assign err0      = err2_q[0];
   assign err1      = err2_q[1];
   assign collision = coll2_q;
`else
   assign dout0     = dout_c[0];
   assign dout1     = dout_c[1];
   assign ack0      = ack_q[0];
   assign ack1      = ack_q[1];
   assign err0      = err_q[0];
   assign err1      = err_q[1];
   assign collision = coll_q;
`endif
endmodule

// File: tb/tb_synth_multi_region_dual_port_memory.sv
// Directed bench for synth_multi_region_dual_port_memory; honours MEM_OUT_REG_EN latency.

module tb_synth_multi_region_dual_port_memory;
`ifdef MEM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rstb;
   logic        req0, req1, wr_ena0, wr_ena1;
   logic [3:0]  be0, be1;
   logic [31:0] addr0, addr1, din0, din1;
   logic [31:0] dout0, dout1;
   logic        ack0, ack1, err0, err1, collision;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   synth_multi_region_dual_port_memory dut (
      .clk(clk), .rstb(rstb),
      .req0(req0), .req1(req1), .wr_ena0(wr_ena0), .wr_ena1(wr_ena1),
      .be0(be0), .be1(be1), .addr0(addr0), .addr1(addr1),
      .din0(din0), .din1(din1), .dout0(dout0), .dout1(dout1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
      .collision(collision)
   );

   task automatic drv0(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
      req0 = r; wr_ena0 = w; be0 = b; addr0 = a; din0 = d;
   endtask

   task automatic drv1(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
      req1 = r; wr_ena1 = w; be1 = b; addr1 = a; din1 = d;
   endtask

   task automatic idle();
      drv0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drv1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Accept the driven request, go idle, and stop in its ack cycle.
   task automatic finish_op();
      step();
      idle();
      repeat (LAT - 1) step();
   endtask

   task automatic test_reset();
      rstb = 1'b0;
      idle();
      repeat (2) step();
      total++; if (dout0 !== 32'h0) $display("FAIL rst_dout0 got %h want 0", dout0); else passed++;
      total++; if (dout1 !== 32'h0) $display("FAIL rst_dout1 got %h want 0", dout1); else passed++;
      total++; if ({ack0, ack1, err0, err1, collision} !== 5'b0)
         $display("FAIL rst_flags got %b want 00000", {ack0, ack1, err0, err1, collision}); else passed++;
      // Release with a request already pending: it must be dropped.
      drv0(1'b1, 1'b0, 4'h0, 32'h4000_0000, 32'h0);
      rstb = 1'b1;
      step();
      idle();
      repeat (LAT) step();
      total++; if (ack0 !== 1'b0) $display("FAIL rst_release_drop got ack0=%b want 0", ack0); else passed++;
   endtask

   task automatic test_write_read();
      drv1(1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
      finish_op();
      total++; if ({ack1, err1} !== 2'b10) $display("FAIL wr_ack got ack/err=%b want 10", {ack1, err1}); else passed++;
      drv1(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
      finish_op();
      total++; if ({ack1, err1} !== 2'b10) $display("FAIL rd_ack got ack/err=%b want 10", {ack1, err1}); else passed++;
      total++; if (dout1 !== 32'hDEAD_BEEF) $display("FAIL rd_data got %h want deadbeef", dout1); else passed++;
      // be=0 write: acked, no change, dout holds.
      drv1(1'b1, 1'b1, 4'h0, 32'h0000_0010, 32'h1234_5678);
      finish_op();
      total++; if (ack1 !== 1'b1) $display("FAIL be0_ack got %b want 1", ack1); else passed++;
      total++; if (dout1 !== 32'hDEAD_BEEF) $display("FAIL dout_hold got %h want deadbeef", dout1); else passed++;
      drv1(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
      finish_op();
      total++; if (dout1 !== 32'hDEAD_BEEF) $display("FAIL be0_nochange got %h want deadbeef", dout1); else passed++;
   endtask

   task automatic test_byte_lanes();
      drv0(1'b1, 1'b1, 4'hF, 32'h4000_0008, 32'h1122_3344);
      finish_op();
      drv0(1'b1, 1'b1, 4'b0010, 32'h4000_0008, 32'hAABB_CCDD);
      finish_op();
      drv0(1'b1, 1'b0, 4'h0, 32'h4000_0008, 32'h0);
      finish_op();
      total++; if ({ack0, err0} !== 2'b10) $display("FAIL lane_ack got %b want 10", {ack0, err0}); else passed++;
      total++; if (dout0 !== 32'h1122_CC44) $display("FAIL lane_data got %h want 1122cc44", dout0); else passed++;
   endtask

   task automatic test_collision();
      drv1(1'b1, 1'b1, 4'hF, 32'h0000_0020, 32'h0);
      finish_op();
      drv0(1'b1, 1'b1, 4'b1100, 32'h0000_0020, 32'hFFFF_0000);
      drv1(1'b1, 1'b1, 4'b0110, 32'h0000_0020, 32'h1234_5678);
      finish_op();
      total++; if (collision !== 1'b1) $display("FAIL coll_pulse got %b want 1", collision); else passed++;
      step();
      total++; if (collision !== 1'b0) $display("FAIL coll_one_cycle got %b want 0", collision); else passed++;
      drv0(1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0);
      finish_op();
      total++; if (dout0 !== 32'hFFFF_5600) $display("FAIL coll_merge got %h want ffff5600", dout0); else passed++;
      // Same index, different regions: independent, no collision.
      drv0(1'b1, 1'b1, 4'hF, 32'h4000_0020, 32'h0BAD_F00D);
      drv1(1'b1, 1'b1, 4'hF, 32'h0000_0020, 32'h7777_8888);
      finish_op();
      total++; if (collision !== 1'b0) $display("FAIL coll_xregion got %b want 0", collision); else passed++;
      drv0(1'b1, 1'b0, 4'h0, 32'h4000_0020, 32'h0);
      drv1(1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0);
      finish_op();
      total++; if (dout0 !== 32'h0BAD_F00D) $display("FAIL xregion_i got %h want 0badf00d", dout0); else passed++;
      total++; if (dout1 !== 32'h7777_8888) $display("FAIL xregion_d got %h want 77778888", dout1); else passed++;
   endtask

   task automatic test_errors();
      drv1(1'b1, 1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D);
      finish_op();
      drv1(1'b1, 1'b0, 4'h0, 32'h0000_0013, 32'h0);
      finish_op();
      total++; if ({ack1, err1} !== 2'b11) $display("FAIL mis_err got %b want 11", {ack1, err1}); else passed++;
      total++; if (dout1 !== 32'h0) $display("FAIL mis_dout got %h want 0", dout1); else passed++;
      drv1(1'b1, 1'b0, 4'h0, 32'h0000_1000, 32'h0);
      finish_op();
      total++; if ({ack1, err1} !== 2'b11) $display("FAIL oor_err got %b want 11", {ack1, err1}); else passed++;
      total++; if (dout1 !== 32'h0) $display("FAIL oor_dout got %h want 0", dout1); else passed++;
      drv0(1'b1, 1'b0, 4'h0, 32'h4000_0800, 32'h0);
      finish_op();
      total++; if ({ack0, err0} !== 2'b11) $display("FAIL ioor_err got %b want 11", {ack0, err0}); else passed++;
      // Errored writes that would alias word 0 and word 4 must not land.
      drv1(1'b1, 1'b1, 4'hF, 32'h0000_1000, 32'hBAD0_BAD0);
      finish_op();
      total++; if ({ack1, err1} !== 2'b11) $display("FAIL oor_wr_err got %b want 11", {ack1, err1}); else passed++;
      drv1(1'b1, 1'b1, 4'hF, 32'h0000_0011, 32'hBAD1_BAD1);
      finish_op();
      drv1(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0);
      finish_op();
      total++; if (dout1 !== 32'hCAFE_F00D) $display("FAIL oor_wr_nochange got %h want cafef00d", dout1); else passed++;
      drv1(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
      finish_op();
      total++; if (dout1 !== 32'hDEAD_BEEF) $display("FAIL mis_wr_nochange got %h want deadbeef", dout1); else passed++;
   endtask

   task automatic test_read_during_write();
      drv1(1'b1, 1'b1, 4'hF, 32'h4000_0000, 32'h0);
      finish_op();
      drv0(1'b1, 1'b0, 4'h0, 32'h4000_0000, 32'h0);
      drv1(1'b1, 1'b1, 4'hF, 32'h4000_0000, 32'h0000_0055);
      finish_op();
      total++; if ({ack0, ack1} !== 2'b11) $display("FAIL rdw_acks got %b want 11", {ack0, ack1}); else passed++;
      total++; if (dout0 !== 32'h0) $display("FAIL rdw_old got %h want 0", dout0); else passed++;
      drv0(1'b1, 1'b0, 4'h0, 32'h4000_0000, 32'h0);
      finish_op();
      total++; if (dout0 !== 32'h0000_0055) $display("FAIL rdw_new got %h want 55", dout0); else passed++;
   endtask

   task automatic test_back_to_back();
      logic        ack_s  [6];
      logic [31:0] dout_s [6];
      for (int c = 0; c < 6; c++) begin
         case (c)
            0: drv1(1'b1, 1'b1, 4'hF, 32'h0000_0030, 32'hA5A5_A5A5);
            1: drv1(1'b1, 1'b0, 4'h0, 32'h0000_0030, 32'h0);
            2: drv1(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
            default: idle();
         endcase
         step();
         ack_s[c]  = ack1;
         dout_s[c] = dout1;
      end
      idle();
      for (int c = LAT - 1; c <= LAT + 1; c++) begin
         total++; if (ack_s[c] !== 1'b1) $display("FAIL b2b_ack%0d got %b want 1", c, ack_s[c]); else passed++;
      end
      total++; if (ack_s[LAT+2] !== 1'b0) $display("FAIL b2b_ack_end got %b want 0", ack_s[LAT+2]); else passed++;
      total++; if (dout_s[LAT] !== 32'hA5A5_A5A5) $display("FAIL b2b_rd0 got %h want a5a5a5a5", dout_s[LAT]); else passed++;
      total++; if (dout_s[LAT+1] !== 32'hDEAD_BEEF) $display("FAIL b2b_rd1 got %h want deadbeef", dout_s[LAT+1]); else passed++;
   endtask

   task automatic test_async_reset();
      drv0(1'b1, 1'b0, 4'h0, 32'h4000_0002, 32'h0);
      repeat (LAT + 2) step();
      total++; if ({ack0, err0} !== 2'b11) $display("FAIL pre_arst got %b want 11", {ack0, err0}); else passed++;
      #2 rstb = 1'b0;
      #1;
      total++; if ({ack0, err0} !== 2'b00) $display("FAIL arst_flags got %b want 00", {ack0, err0}); else passed++;
      total++; if (dout0 !== 32'h0) $display("FAIL arst_dout got %h want 0", dout0); else passed++;
      @(negedge clk);
      rstb = 1'b1;
      step();
      idle();
      repeat (LAT) step();
      total++; if (ack0 !== 1'b0) $display("FAIL arst_release_drop got %b want 0", ack0); else passed++;
      drv0(1'b1, 1'b0, 4'h0, 32'h4000_0008, 32'h0);
      finish_op();
      total++; if (dout0 !== 32'h1122_CC44) $display("FAIL arst_mem_kept got %h want 1122cc44", dout0); else passed++;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_collision();
      test_errors();
      test_read_during_write();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
